// File: rtl/spi_transfer_sequencer.sv
// spi_transfer_sequencer: frames one SPI transaction at a time (CS setup/hold/gap, gated SCLK, MSB-first MOSI).
// Define SPI_SEQ_READBACK_EN to compile in MISO capture and the response channel.
module spi_transfer_sequencer #(
  parameter int MAX_BITS = 32,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int GAP      = 1
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_cpol,
  input  logic                          req_cpha,
  input  logic [$clog2(MAX_BITS+1)-1:0] req_nbits,
  input  logic [MAX_BITS-1:0]           req_wdata,
  output logic                          cpol,
  output logic                          cpha,
  output logic                          sclk_en,
  output logic                          cs_n,
  output logic                          mosi,
  input  logic                          miso,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [MAX_BITS-1:0]           rsp_rdata,
  output logic                          busy
);
  localparam int NW   = $clog2(MAX_BITS+1);
  localparam int CM_A = MAX_BITS > CS_SETUP ? MAX_BITS : CS_SETUP;
  localparam int CM_B = CS_HOLD > GAP ? CS_HOLD : GAP;
  localparam int CMAX = CM_A > CM_B ? CM_A : CM_B;
  localparam int CW   = CMAX > 1 ? $clog2(CMAX) : 1;

`ifdef SPI_SEQ_READBACK_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETUP, S_SHIFT, S_HOLD, S_GAP, S_RESP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;
`endif

  state_t              r_state, w_next;
  logic [CW-1:0]       r_cnt, w_len_m1;
  logic [NW-1:0]       r_nbits, w_nbits;
  logic [MAX_BITS-1:0] r_sh;
  logic                r_lat_cpol, r_lat_cpha, r_cpol, r_cpha, r_sclk_en, r_cs_n, r_mosi;
  logic                w_last, w_counting, w_accept;

  assign req_ready  = (r_state == S_IDLE) && aresetn;
  assign busy       = r_state != S_IDLE;
  assign w_accept   = req_valid && req_ready;
  assign w_nbits    = req_nbits == '0 ? NW'(1) : (req_nbits > NW'(MAX_BITS) ? NW'(MAX_BITS) : req_nbits);
  assign w_counting = r_state inside {S_SETUP, S_SHIFT, S_HOLD, S_GAP};
  assign w_len_m1   = r_state == S_SETUP ? CW'(CS_SETUP - 1) :
                      r_state == S_SHIFT ? CW'(r_nbits - NW'(1)) :
                      r_state == S_HOLD  ? CW'(CS_HOLD - 1) : CW'(GAP - 1);
  assign w_last     = r_cnt == w_len_m1;
  assign cpol       = r_cpol;
  assign cpha       = r_cpha;
  assign sclk_en    = r_sclk_en;
  assign cs_n       = r_cs_n;
  assign mosi       = r_mosi;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = req_valid ? S_LOAD : S_IDLE;
      S_LOAD:  w_next = S_SETUP;
      S_SETUP: w_next = w_last ? S_SHIFT : S_SETUP;
      S_SHIFT: w_next = w_last ? S_HOLD : S_SHIFT;
      S_HOLD:  w_next = w_last ? S_GAP : S_HOLD;
`ifdef SPI_SEQ_READBACK_EN
      S_GAP:   w_next = w_last ? S_RESP : S_GAP;
      S_RESP:  w_next = rsp_ready ? S_IDLE : S_RESP;
`else
      S_GAP:   w_next = w_last ? S_IDLE : S_GAP;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) r_state <= S_IDLE;
    else          r_state <= w_next;

  // Pad/mode outputs are registered decodes of the state, so they trail it by one cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt      <= '0;
      r_nbits    <= '0;
      r_sh       <= '0;
      r_lat_cpol <= 1'b0;
      r_lat_cpha <= 1'b0;
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_sclk_en  <= 1'b0;
      r_cs_n     <= 1'b1;
      r_mosi     <= 1'b0;
    end else begin
      r_cnt <= (w_counting && w_next == r_state) ? r_cnt + 1'b1 : '0;
      if (w_accept) begin
        r_nbits    <= w_nbits;
        r_sh       <= req_wdata << (NW'(MAX_BITS) - w_nbits);
        r_lat_cpol <= req_cpol;
        r_lat_cpha <= req_cpha;
      end else if (r_state == S_SHIFT) begin
        r_sh <= r_sh << 1;
      end
      if (r_state == S_LOAD) begin
        r_cpol <= r_lat_cpol;
        r_cpha <= r_lat_cpha;
      end
      r_cs_n    <= !(r_state inside {S_SETUP, S_SHIFT, S_HOLD});
      r_sclk_en <= r_state == S_SHIFT;
      r_mosi    <= (r_state == S_SETUP || r_state == S_SHIFT) && r_sh[MAX_BITS-1];
    end
  end

`ifdef SPI_SEQ_READBACK_EN
  logic [MAX_BITS-1:0] r_rx;
  // MISO is taken at the edge closing each bit window in which sclk_en is high.
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn)       r_rx <= '0;
    else if (w_accept)  r_rx <= '0;
    else if (r_sclk_en) r_rx <= {r_rx[MAX_BITS-2:0], miso};
  assign rsp_valid = r_state == S_RESP;
  assign rsp_rdata = rsp_valid ? r_rx : '0;
`else
  logic w_unused;
  assign w_unused  = miso ^ rsp_ready;
  assign rsp_valid = 1'b0;
  assign rsp_rdata = '0;
`endif
endmodule

// File: doc/spi_transfer_sequencer.md
# spi_transfer_sequencer

Sequences single SPI transactions on the shared SPI clock path. Accepts one request at a time over a valid/ready channel and latches the transaction's CPOL/CPHA onto the SPI clock generator's mode inputs while CS is high. It then frames the transfer with chip-select setup/hold/gap timing, gates the SPI clock for exactly the requested number of bit periods, shifts MOSI out MSB-first, and optionally returns the MISO word on a response channel. Sits between the register/sequencer logic and the SPI clock generator plus pad drivers; one SPI bit period equals one `aclk` cycle.

## Interface
- `MAX_BITS`, 32: largest transfer length; also the width of the data ports.
- `CS_SETUP`, 2: cycles `cs_n` is low before the first bit (≥1).
- `CS_HOLD`, 2: cycles `cs_n` stays low after the last bit (≥1).
- `GAP`, 1: cycles `cs_n` is high after HOLD before the next transaction (≥1).
- `aclk`  in  1  system clock; the 0° SPI reference.
- `aresetn`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request valid.
- `req_ready`  out  1  request ready.
- `req_cpol`  in  1  CPOL for this transaction.
- `req_cpha`  in  1  CPHA for this transaction.
- `req_nbits`  in  $clog2(MAX_BITS+1)  bit count.
- `req_wdata`  in  MAX_BITS  transmit word, right-aligned.
- `cpol`  out  1  mode to clock generator, registered.
- `cpha`  out  1  mode to clock generator, registered.
- `sclk_en`  out  1  SPI clock gate enable, registered.
- `cs_n`  out  1  chip select, active-low, registered.
- `mosi`  out  1  serial data out, registered.
- `miso`  in  1  serial data in.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response ready.
- `rsp_rdata`  out  MAX_BITS  received word, right-aligned.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Reset values: `req_ready`=0, `cpol`=0, `cpha`=0, `sclk_en`=0, `cs_n`=1, `mosi`=0, `rsp_valid`=0, `rsp_rdata`=0, `busy`=0. The FSM resets to IDLE.
- States: IDLE → LOAD → SETUP → SHIFT → HOLD → GAP → (RESP if readback) → IDLE.
- IDLE: `req_ready`=1, except while `aresetn` is low. On `req_valid & req_ready`, latch the request and go to LOAD.
- Length rule: `req_nbits`=0 is treated as 1. Values above `MAX_BITS` are clamped to `MAX_BITS`.
- LOAD (1 cycle): `cpol`/`cpha` take the latched values. `cs_n` stays 1, so the mode only ever changes while CS is deasserted. `cpol`/`cpha` hold their values through IDLE until the next LOAD.
- SETUP (`CS_SETUP` cycles): `cs_n`=0. `mosi` = wdata[nbits-1].
- SHIFT (nbits cycles): `sclk_en`=1.
  - In SHIFT cycle k (0-based), `mosi` = wdata[nbits-1-k].
  - `miso` is sampled at the aclk edge ending each SHIFT cycle and shifted into the LSB of the receive register.
- HOLD (`CS_HOLD` cycles): `cs_n`=0, `sclk_en`=0, `mosi`=0.
- GAP (`GAP` cycles): `cs_n`=1.
- RESP: `rsp_valid`=1 and `rsp_rdata` = received word with upper bits zero. Both hold until `rsp_ready`, then return to IDLE.
- `req_ready` is 0 in every non-IDLE state. Requests presented while busy are not accepted and not lost; the requester holds them.
- Counters are sized `$clog2` of their maximum, with no wrap. The bit counter terminates at nbits-1.
- Reset mid-transaction: outputs return to reset values immediately (asynchronously) and no response is produced.

## Timing
- Accept edge = edge 0. `cpol`/`cpha` update at edge 1, `cs_n` falls at edge 2, and `sclk_en` rises at edge 2+`CS_SETUP`.
- `sclk_en` is high for exactly nbits cycles.
- `rsp_valid` rises at edge 1+`CS_SETUP`+nbits+`CS_HOLD`+`GAP`. With defaults and nbits=8, that is edge 14.
- Back-to-back requests: the next accept is at the earliest in the IDLE cycle after RESP completes (or after GAP without readback). Minimum CS-high time between transactions is `GAP`+2 cycles.
- `rsp_ready` held high: RESP lasts exactly 1 cycle.

## Configuration
- `SPI_SEQ_READBACK_EN` defined:
  - MISO capture and the RESP state are compiled in.
  - The response channel behaves as above.
- `SPI_SEQ_READBACK_EN` undefined:
  - No receive register and no RESP state.
  - `miso` and `rsp_ready` are ignored; `rsp_valid` and `rsp_rdata` are tied 0.
  - GAP returns directly to IDLE.
  - The port list is unchanged.

## Test plan
- Reset then idle: after `aresetn` release, `req_ready`=1, `cs_n`=1, `sclk_en`=0, `cpol`=`cpha`=0.
- Request nbits=8, wdata=0xA5, cpol=0, cpha=0, `miso` driving 0x3C MSB-first, `rsp_ready`=1 → `mosi` sequence 1,0,1,0,0,1,0,1; `sclk_en` high for 8 cycles; `rsp_valid` at edge 14 with `rsp_rdata`=0x3C.
- Mode change: request cpol=1, cpha=1, then cpol=0, cpha=1 → `cpol`/`cpha` change only while `cs_n`=1, one cycle before `cs_n` falls.
- Boundaries: nbits=0 → 1 `sclk_en` cycle; nbits=40 → 32 cycles; nbits=32, wdata=0x80000001 → `mosi` first bit 1, last bit 1.
- Backpressure: hold `rsp_ready`=0 for 5 cycles with a second `req_valid` pending → `rsp_valid`/`rsp_rdata` stable, `req_ready`=0; second request accepted in the IDLE cycle after the handshake.
- Reset mid-SHIFT (bit 3 of 8) → `cs_n`=1 and `sclk_en`=0 asynchronously; no `rsp_valid`; next request runs normally.
